uart_tx_fifo: RTL

//  Parametrised async UART transmitter with an input FIFO and runtime frame format.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Frame format captured when a character is popped.
  typedef struct packed {
    logic [1:0] bits;
    parity_e    parity;
    logic       stop2;
  } frame_cfg_t;

  localparam int MIN_CLKS_PER_BIT = 4;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy counter; push when full is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame format (5-8 bits, parity, 1/2 stop) latched per character.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 1000000,
  parameter int DEPTH    = 16,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] level
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(CPB);

  generate
    if (CPB < MIN_CLKS_PER_BIT || (CLK_FREQ % BAUD) != 0) begin : g_bad_baud
      $error("uart_tx_fifo: CLK_FREQ/BAUD must be an integer >= 4");
    end
  endgenerate

  tx_state_e        state, nxt_state;
  frame_cfg_t       cfg_q, cfg_in;
  logic [7:0]       shift;
  logic             par_acc;
  logic [2:0]       idx;
  logic [CNT_W-1:0] baud_cnt;
  logic             bit_tick, last_data, last_stop, frame_load;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (frame_load),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = ~fifo_full;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;
  assign bit_tick  = (baud_cnt == CNT_W'(CPB - 1));
  assign last_data = (idx == 3'(cfg_q.bits) + 3'd4);
  assign last_stop = (idx == {2'b00, cfg_q.stop2});

  // Reserved parity code behaves as no parity.
  always_comb begin
    cfg_in.bits  = cfg_bits;
    cfg_in.stop2 = cfg_stop2;
    case (cfg_parity)
      2'd1:    cfg_in.parity = PAR_EVEN;
      2'd2:    cfg_in.parity = PAR_ODD;
      default: cfg_in.parity = PAR_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) nxt_state = ST_START;
      ST_START:  if (bit_tick) nxt_state = ST_DATA;
      ST_DATA:   if (bit_tick && last_data)
                   nxt_state = (cfg_q.parity != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) nxt_state = ST_STOP;
      ST_STOP:   if (bit_tick && last_stop) nxt_state = ST_IDLE;
      default:   nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    frame_load = 1'b0;
    case (state)
      ST_IDLE:   frame_load = ~fifo_empty;
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift[0];
      ST_PARITY: tx = (cfg_q.parity == PAR_ODD) ? ~par_acc : par_acc;
      default:   tx = 1'b1;
    endcase
  end

  // idx counts data bits, then is reused to count stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      cfg_q    <= '{bits: 2'd3, parity: PAR_NONE, stop2: 1'b0};
      shift    <= '0;
      par_acc  <= 1'b0;
      idx      <= '0;
    end else begin
      if (state == ST_IDLE || bit_tick) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + CNT_W'(1);

      if (frame_load) begin
        shift   <= fifo_rdata;
        cfg_q   <= cfg_in;
        par_acc <= 1'b0;
        idx     <= '0;
      end else if (bit_tick) begin
        case (state)
          ST_DATA: begin
            shift   <= {1'b0, shift[7:1]};
            par_acc <= par_acc ^ shift[0];
            idx     <= last_data ? 3'd0 : idx + 3'd1;
          end
          ST_STOP: idx <= idx + 3'd1;
          default: idx <= idx;
        endcase
      end
    end
  end

endmodule
